// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encodings, default width,
// and the counter-width helper.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must reach WIDTH without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder; the master issues operands and
// start, the slave returns busy/done and the registered result.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell used as the serial adder's datapath.
module full_adder (
  output logic S,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures operands on start, adds one bit per clock LSB
// first through a single full-adder cell, and pulses done after WIDTH shifts.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  full_adder u_fa (
    .S    (fa_s),
    .Cout (fa_c),
    .A    (a_sr_q[0]),
    .B    (b_sr_q[0]),
    .Cin  (carry_q)
  );

  // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign sum_d    = {fa_s, sum_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr_q  <= bus.a;
            b_sr_q  <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          sum_q   <= sum_d;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            cout_q  <= fa_c;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=4, using vector
// tables, an exhaustive 4-bit sweep and a done-pulse scoreboard.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  typedef struct {
    logic [8:0] res;
    int         due;
  } exp_t;

  exp_t sb8[$];
  exp_t sb4[$];
  int   pushes8 = 0, pushes4 = 0;
  int   dones8 = 0, dones4 = 0;
  logic prev_done8 = 1'b0, prev_done4 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard consumers: one pop per done pulse, checked mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done8 = 1'b0;
    end else begin
      if (if8.done === 1'b1) begin
        exp_t e;
        dones8++;
        chk("done8_busy", if8.busy, 1);
        chk("done8_double", prev_done8, 0);
        if (sb8.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done8_unexpected actual=done required=idle cyc=%0d", cyc);
        end else begin
          e = sb8.pop_front();
          chk("sum8", {if8.cout, if8.sum}, e.res);
          chk("latency8", cyc, e.due);
        end
      end
      prev_done8 = if8.done;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done4 = 1'b0;
    end else begin
      if (if4.done === 1'b1) begin
        exp_t e;
        dones4++;
        chk("done4_double", prev_done4, 0);
        if (sb4.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done4_unexpected actual=done required=idle cyc=%0d", cyc);
        end else begin
          e = sb4.pop_front();
          chk("sum4", {if4.cout, if4.sum}, e.res);
          chk("latency4", cyc, e.due);
        end
      end
      prev_done4 = if4.done;
    end
  end

  task automatic wait_sb8();
    int t = 0;
    while (sb8.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb8.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout8 actual_pending=%0d required=0", sb8.size());
      sb8.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_sb4();
    int t = 0;
    while (sb4.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb4.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout4 actual_pending=%0d required=0", sb4.size());
      sb4.delete();
    end
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; start is sampled at the next edge.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [8:0] res, input bit scramble);
    exp_t e;
    if8.a = a; if8.b = b; if8.cin = cin; if8.start = 1'b1;
    @(posedge clk); #1;
    e.res = res;
    e.due = cyc + 8;
    sb8.push_back(e);
    pushes8++;
    if8.start = 1'b0;
    if (scramble) begin
      if8.a = 8'($urandom);
      if8.b = 8'($urandom);
      if8.cin = 1'($urandom);
    end
    chk("busy8_after_start", if8.busy, 1);
    wait_sb8();
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    exp_t e;
    int   s;
    s = int'(a) + int'(b) + int'(cin);
    if4.a = a; if4.b = b; if4.cin = cin; if4.start = 1'b1;
    @(posedge clk); #1;
    e.res = 9'(s);
    e.due = cyc + 4;
    sb4.push_back(e);
    pushes4++;
    if4.start = 1'b0;
    if4.a = 4'($urandom);
    if4.b = 4'($urandom);
    if4.cin = 1'($urandom);
    wait_sb4();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   k;
    exp_t e;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[5] = '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1};

    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy8", if8.busy, 0);
    chk("rst_done8", if8.done, 0);
    chk("rst_sum8", {if8.cout, if8.sum}, 0);
    chk("rst_sum4", {if4.busy, if4.done, if4.cout, if4.sum}, 0);
    rst_n = 1'b1;

    // Table vectors, alternately scrambling operands after the start edge.
    for (int i = 0; i < 6; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum}, (i % 2) == 1);
      @(negedge clk);
      chk("hold_sum8", if8.sum, vecs[i].sum);
      chk("hold_cout8", if8.cout, vecs[i].cout);
      chk("idle_busy8", if8.busy, 0);
    end

    // Exhaustive 4-bit sweep.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      run4(v[3:0], v[7:4], v[8]);
    end

    // start held high for 30 cycles: accepts every WIDTH+2 = 10 edges.
    if8.a = 8'h03; if8.b = 8'h04; if8.cin = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    for (int j = 0; j < 3; j++) begin
      e.res = 9'h007;
      e.due = k + 8 + 10 * j;
      sb8.push_back(e);
      pushes8++;
    end
    repeat (29) @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    wait_sb8();
    chk("held_final_sum8", if8.sum, 8'h07);

    // Reset in the 4th SHIFT cycle abandons the operation.
    if8.a = 8'h55; if8.b = 8'h22; if8.cin = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midshift_busy8", if8.busy, 1);
    chk("midshift_sum8", if8.sum, 8'hE0);
    rst_n = 1'b0;
    #1;
    chk("arst_busy8", if8.busy, 0);
    chk("arst_done8", if8.done, 0);
    chk("arst_sum8", if8.sum, 0);
    chk("arst_cout8", if8.cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h10, 8'h20, 1'b0, 9'h030, 1'b1);
    repeat (12) @(negedge clk);

    chk("pulses8", dones8, pushes8);
    chk("pulses4", dones4, pushes4);
    chk("sb8_empty", sb8.size(), 0);
    chk("sb4_empty", sb4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
